axi4_lite_traffic_seq: RTL and testbench

Sequencer for the AXI4-Lite traffic generator. On a go request it runs the generator NUM_ITERS times back to back. Before each pass it resets the generator, then starts it and waits for done. Per pass it samples the read/write error flags, measures run time, enforces a timeout, and reports aggregate pass/fail for board LEDs/debug.

---
 rtl/axi4_lite_traffic_seq.sv | 147 ++++++++++++++
 tb/tb_axi4_lite_traffic_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_traffic_seq.sv
// Runs the AXI4-Lite traffic generator NUM_ITERS times per go (reset, settle, run, collect); AXI_TRAFFIC_SEQ_STOP_ON_ERROR_EN ends early on an errored pass.
// Latency: RESET_HOLD_CYCLES + SETTLE_CYCLES + run time + 1 cycles per pass; no backpressure, go_i is ignored while busy_o.
module axi4_lite_traffic_seq #(
  parameter int          NUM_ITERS         = 4,
  parameter int          ITER_W            = 8,
  parameter int          RESET_HOLD_CYCLES = 4,
  parameter int          SETTLE_CYCLES     = 3,
  parameter logic [31:0] TIMEOUT_CYCLES    = 32'h0100_0000
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              go_i,
  output logic              tg_reset_n_o,
  output logic              tg_start_o,
  input  logic              tg_done_i,
  input  logic              tg_rd_error_i,
  input  logic              tg_wr_error_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [7:0]        rd_err_cnt_o,
  output logic [7:0]        wr_err_cnt_o,
  output logic [ITER_W-1:0] iter_o,
  output logic [31:0]       last_run_cycles_o
);

  localparam int HOLD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_TG_RST, S_SETTLE, S_RUN, S_NEXT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q;
  logic [31:0]        run_q;
  logic               launch;
  logic               timeout_hit;
`ifdef AXI_TRAFFIC_SEQ_STOP_ON_ERROR_EN
  logic               last_err_q;
`endif

  assign launch      = ((state_q == S_IDLE) || (state_q == S_DONE)) && go_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (run_q == TIMEOUT_CYCLES);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Outputs are decoded from state so the async reset reaches the generator immediately.
  always_comb begin
    state_d      = state_q;
    tg_reset_n_o = 1'b0;
    tg_start_o   = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_i) state_d = S_TG_RST;
      end
      S_TG_RST: begin
        busy_o = 1'b1;
        if (hold_q == HOLD_W'(RESET_HOLD_CYCLES - 1)) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        busy_o       = 1'b1;
        tg_reset_n_o = 1'b1;
        if (hold_q == HOLD_W'(SETTLE_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        busy_o       = 1'b1;
        tg_reset_n_o = 1'b1;
        tg_start_o   = 1'b1;
        if (tg_done_i)        state_d = S_NEXT;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_NEXT: begin
        busy_o       = 1'b1;
        tg_reset_n_o = 1'b1;
`ifdef AXI_TRAFFIC_SEQ_STOP_ON_ERROR_EN
        if ((iter_o == ITER_W'(NUM_ITERS)) || last_err_q) state_d = S_DONE;
`else
        if (iter_o == ITER_W'(NUM_ITERS)) state_d = S_DONE;
`endif
        else state_d = S_TG_RST;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (go_i) state_d = S_TG_RST;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pass_o = done_o && (rd_err_cnt_o == 8'd0) && (wr_err_cnt_o == 8'd0) && !timeout_o;

  // Shared dwell counter for TG_RST and SETTLE; restarts on every state change.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_q <= '0;
      run_q  <= '0;
    end else begin
      if (state_d != state_q) hold_q <= '0;
      else if ((state_q == S_TG_RST) || (state_q == S_SETTLE)) hold_q <= hold_q + HOLD_W'(1);

      if ((state_q == S_SETTLE) && (state_d == S_RUN)) run_q <= 32'd1;
      else if ((state_q == S_RUN) && (run_q != 32'hFFFF_FFFF)) run_q <= run_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      iter_o            <= '0;
      rd_err_cnt_o      <= '0;
      wr_err_cnt_o      <= '0;
      timeout_o         <= 1'b0;
      last_run_cycles_o <= '0;
`ifdef AXI_TRAFFIC_SEQ_STOP_ON_ERROR_EN
      last_err_q        <= 1'b0;
`endif
    end else if (launch) begin
      iter_o            <= '0;
      rd_err_cnt_o      <= '0;
      wr_err_cnt_o      <= '0;
      timeout_o         <= 1'b0;
      last_run_cycles_o <= '0;
`ifdef AXI_TRAFFIC_SEQ_STOP_ON_ERROR_EN
      last_err_q        <= 1'b0;
`endif
    end else if (state_q == S_RUN) begin
      if (tg_done_i) begin
        last_run_cycles_o <= run_q;
        iter_o            <= iter_o + ITER_W'(1);
        if (tg_rd_error_i && (rd_err_cnt_o != 8'hFF)) rd_err_cnt_o <= rd_err_cnt_o + 8'd1;
        if (tg_wr_error_i && (wr_err_cnt_o != 8'hFF)) wr_err_cnt_o <= wr_err_cnt_o + 8'd1;
`ifdef AXI_TRAFFIC_SEQ_STOP_ON_ERROR_EN
        last_err_q        <= tg_rd_error_i || tg_wr_error_i;
`endif
      end else if (timeout_hit) begin
        timeout_o         <= 1'b1;
        last_run_cycles_o <= run_q;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_traffic_seq.sv
// Bench for axi4_lite_traffic_seq: behavioural generator, vector table with queued expectations, reset-window monitor.
module tb_axi4_lite_traffic_seq;

  localparam int TO = 60;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        go_i = 1'b0;
  logic        tg_reset_n_o, tg_start_o;
  logic        tg_done_i = 1'b0, tg_rd_error_i = 1'b0, tg_wr_error_i = 1'b0;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [7:0]  rd_err_cnt_o, wr_err_cnt_o;
  logic [7:0]  iter_o;
  logic [31:0] last_run_cycles_o;

  axi4_lite_traffic_seq #(
    .NUM_ITERS(3), .ITER_W(8), .RESET_HOLD_CYCLES(4), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(32'(TO))
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .go_i(go_i),
    .tg_reset_n_o(tg_reset_n_o), .tg_start_o(tg_start_o), .tg_done_i(tg_done_i),
    .tg_rd_error_i(tg_rd_error_i), .tg_wr_error_i(tg_wr_error_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .rd_err_cnt_o(rd_err_cnt_o), .wr_err_cnt_o(wr_err_cnt_o),
    .iter_o(iter_o), .last_run_cycles_o(last_run_cycles_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-pass generator behaviour; masks are indexed by pass number 1..3.
  typedef struct {
    int         delay;
    logic [3:0] rd_m;
    logic [3:0] wr_m;
    int         hang;
    int         e_iter;
    int         e_rd;
    int         e_wr;
    bit         e_to;
    bit         e_pass;
    int         e_last;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];

  int         cur_delay = 1;
  logic [3:0] cur_rd = '0, cur_wr = '0;
  int         cur_hang = 0;
  int         windows = 0, gpass = 0, gcnt = 0;
  int         low_len = 0, settle_len = 0;
  logic       prev_rst = 1'b0, prev_start = 1'b0;

  // Generator model and reset/settle window monitor, updated away from the active edge.
  always @(negedge clk) begin
    if (!tg_reset_n_o) begin
      low_len       = busy_o ? low_len + 1 : 0;
      gcnt          = 0;
      tg_done_i     = 1'b0;
      tg_rd_error_i = 1'b0;
      tg_wr_error_i = 1'b0;
    end else begin
      if (!prev_rst) begin
        windows++;
        gpass = windows;
        chk($sformatf("rst_window%0d", windows), low_len, 4);
        low_len    = 0;
        settle_len = 0;
      end
      if (!tg_start_o) settle_len++;
      if (tg_start_o && !prev_start) chk("settle_len", settle_len, 3);
      if (tg_start_o && !tg_done_i) begin
        gcnt++;
        if (gcnt >= cur_delay && gpass != cur_hang) begin
          tg_done_i     = 1'b1;
          tg_rd_error_i = cur_rd[gpass];
          tg_wr_error_i = cur_wr[gpass];
        end
      end
    end
    prev_rst   = tg_reset_n_o;
    prev_start = tg_start_o;
  end

  task automatic launch(input int delay, input logic [3:0] rd_m, input logic [3:0] wr_m, input int hang);
    cur_delay = delay;
    cur_rd    = rd_m;
    cur_wr    = wr_m;
    cur_hang  = hang;
    windows   = 0;
    gpass     = 0;
    @(negedge clk);
    go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
    chk("go_clears_done", done_o, 0);
    chk("go_clears_iter", iter_o, 0);
    chk("go_busy", busy_o, 1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    vec_t e;
    int   c;
    v = vecs[i];
    sb_q.push_back(v);
    launch(v.delay, v.rd_m, v.wr_m, v.hang);
    c = 0;
    while (!done_o && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (!done_o) begin
      chk($sformatf("v%0d_done_wait", i), 0, 1);
      sb_q.delete();
      return;
    end
    e = sb_q.pop_front();
    chk($sformatf("v%0d_iter", i), iter_o, e.e_iter);
    chk($sformatf("v%0d_rd_cnt", i), rd_err_cnt_o, e.e_rd);
    chk($sformatf("v%0d_wr_cnt", i), wr_err_cnt_o, e.e_wr);
    chk($sformatf("v%0d_timeout", i), timeout_o, e.e_to);
    chk($sformatf("v%0d_pass", i), pass_o, e.e_pass);
    chk($sformatf("v%0d_last_run", i), last_run_cycles_o, e.e_last);
    chk($sformatf("v%0d_windows", i), windows, e.e_iter + int'(e.e_to));
    chk($sformatf("v%0d_tg_held", i), {tg_reset_n_o, tg_start_o, busy_o}, 0);
  endtask

  initial begin
    //            delay rd_m     wr_m     hang iter rd wr to pass last
`ifdef AXI_TRAFFIC_SEQ_STOP_ON_ERROR_EN
    vecs[1] = '{20, 4'b0100, 4'b0000, 0,   2,  1, 0, 0, 0,  20};
    vecs[4] = '{ 1, 4'b0000, 4'b1110, 0,   1,  0, 1, 0, 0,   1};
    vecs[5] = '{25, 4'b0010, 4'b0000, 2,   1,  1, 0, 0, 0,  25};
`else
    vecs[1] = '{20, 4'b0100, 4'b0000, 0,   3,  1, 0, 0, 0,  20};
    vecs[4] = '{ 1, 4'b0000, 4'b1110, 0,   3,  0, 3, 0, 0,   1};
    vecs[5] = '{25, 4'b0010, 4'b0000, 2,   1,  1, 0, 1, 0,  TO};
`endif
    vecs[0] = '{40, 4'b0000, 4'b0000, 0,   3,  0, 0, 0, 1,  40};
    vecs[2] = '{10, 4'b0000, 4'b0000, 1,   0,  0, 0, 1, 0,  TO};
    vecs[3] = '{TO, 4'b0000, 4'b0000, 0,   3,  0, 0, 0, 1,  TO};
    vecs[6] = '{59, 4'b0000, 4'b0000, 0,   3,  0, 0, 0, 1,  59};
    vecs[7] = '{30, 4'b1000, 4'b1000, 0,   3,  1, 1, 0, 0,  30};

    repeat (3) @(negedge clk);
    chk("rst_tg_reset_n", tg_reset_n_o, 0);
    chk("rst_start", tg_start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_counts", {rd_err_cnt_o, wr_err_cnt_o, iter_o}, 0);
    chk("rst_last_run", last_run_cycles_o, 0);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_go", {busy_o, done_o, tg_reset_n_o}, 0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Asynchronous reset in the middle of pass 2 after pass 1 logged a read error.
    begin
      int c = 0;
      launch(20, 4'b0010, 4'b0000, 0);
      while (!(windows >= 2 && tg_start_o) && c < 1000) begin
        @(negedge clk);
        c++;
      end
      chk("midrst_reached_pass2_run", tg_start_o, 1);
      repeat (5) @(negedge clk);
      chk("midrst_pre_rd_cnt", rd_err_cnt_o, 1);
      chk("midrst_pre_iter", iter_o, 1);
      #2 reset_n_i = 1'b0;
      #1;
      chk("midrst_tg_reset_n", tg_reset_n_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_start", tg_start_o, 0);
      chk("midrst_counts", {rd_err_cnt_o, wr_err_cnt_o, iter_o}, 0);
      chk("midrst_last_run", last_run_cycles_o, 0);
      @(negedge clk);
      reset_n_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_idle", {busy_o, done_o}, 0);
      run_vec(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
